uart_cfg_regbank: RTL
=====================

UART_CFG_REGBANK -- requirements
Module: uart_cfg_regbank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent UART channels configured (1..8).
REQ-002 SHALL have parameter DATA_W, default 4, write/read data width (4..8).
REQ-003 SHALL have parameter FL_MIN, default 5, and FL_MAX, default 9, legal frame_length range.
REQ-004 SHALL have port clk_16bd  input  1  single clock (16x baud); one clock, no other clock domains.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid  input  1  request strobe.
REQ-007 SHALL have port wr  input  1  1=write, 0=read.
REQ-008 SHALL have port ch_sel  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-009 SHALL have port address  input  4  register address.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port rdata  output  DATA_W  read data, valid while ack high.
REQ-012 SHALL have port ack  output  1  one-cycle success pulse.
REQ-013 SHALL have port nack  output  1  one-cycle error pulse.
REQ-014 SHALL have port ch_idle  input  NUM_CH  per-channel "no frame in flight" from TX/RX.
REQ-015 SHALL have ports parity, parity_type, stop_bits  output  NUM_CH each  active per-channel settings.
REQ-016 SHALL have port frame_length  output  4*NUM_CH  active per-channel frame length, channel n at bits [4n+3:4n].

Function
REQ-017 Register map per channel SHALL be: 0x9 parity enable (bit0), 0xA parity type (bit0), 0xB stop bits (bit0), 0xC frame length (bits 3:0), 0xD commit (write bit0=1 requests commit; read bit0 = pending), 0xE lock (write bit0=1 locks; read bit0 = locked).
REQ-018 Handshake FSM SHALL have states IDLE, RESP, HOLD; valid is sampled only in IDLE.
REQ-019 IDLE SHALL go to RESP when valid=1; the request is decoded and executed on that edge.
REQ-020 In RESP exactly one of ack/nack SHALL be 1 for exactly one cycle, then FSM goes to HOLD.
REQ-021 HOLD SHALL return to IDLE on the first cycle valid=0; a held valid SHALL never cause a second access.
REQ-022 Writes to 0x9-0xC SHALL update the channel's shadow register only; active outputs unchanged.
REQ-023 nack SHALL be returned, with no state change, for: unmapped address, ch_sel >= NUM_CH, any write to a locked channel, frame-length write outside FL_MIN..FL_MAX.
REQ-024 Reads SHALL return shadow value (zero-extended to DATA_W) with ack; reads of a locked channel SHALL succeed.
REQ-025 Commit write SHALL set pending; while pending=1 and ch_idle[n]=1 at a clock edge, active <= shadow and pending clears on that edge; active values SHALL change only on such an edge.
REQ-026 Commit write while ch_idle[n]=1 SHALL set pending, so active updates on the following edge (one-cycle latency from the access edge).
REQ-027 Shadow write on the same edge as a commit transfer SHALL leave active taking the pre-write shadow; the new value awaits the next commit.
REQ-028 Commit write with bit0=0 SHALL ack with no effect; lock write bit0=0 SHALL ack and SHALL NOT unlock.
REQ-029 Lock SHALL be sticky until reset; a commit already pending at lock time SHALL still complete.
REQ-030 Channels SHALL commit independently; commits on different channels may occur on the same edge.

Reset
REQ-031 On rst=1 all state SHALL clear asynchronously: FSM IDLE, ack=0, nack=0, rdata=0, pending=0, locked=0.
REQ-032 Shadow and active per channel SHALL reset to parity=1, parity_type=0, stop_bits=0, frame_length=8.
REQ-033 Reset mid-transaction SHALL abort it with no ack/nack pulse after release.

Structure
REQ-034 Package uart_cfg_pkg SHALL hold address constants, reset defaults and the FSM state enumeration.
REQ-035 Per-channel shadow/active/pending/lock logic SHALL be sub-module uart_cfg_channel, instantiated NUM_CH times.

Verification
REQ-036 Reset, then read ch0 0xC -> ack, rdata=8; outputs parity=1, frame_length=8 on all channels.
REQ-037 Write ch1 0xC=7 with ch_idle[1]=0, commit -> frame_length[7:4] stays 8; raise ch_idle[1] -> becomes 7 on next edge, 0xD reads 0.
REQ-038 Write 0xC=10, address 0x3, ch_sel=NUM_CH -> nack each, state unchanged.
REQ-039 Lock ch0 then write 0x9=0 -> nack; read 0x9 -> ack, rdata=1; lock persists until rst.
REQ-040 Hold valid high 5 cycles on one write -> exactly one ack pulse; assert rst during RESP -> no pulse after release.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART configuration register bank: register
// addresses, per-channel configuration record with its reset value, the
// handshake FSM state encoding and an address-map helper.
package uart_cfg_pkg;

  localparam logic [3:0] ADDR_PAR    = 4'h9;
  localparam logic [3:0] ADDR_PTYPE  = 4'hA;
  localparam logic [3:0] ADDR_STOP   = 4'hB;
  localparam logic [3:0] ADDR_FLEN   = 4'hC;
  localparam logic [3:0] ADDR_COMMIT = 4'hD;
  localparam logic [3:0] ADDR_LOCK   = 4'hE;

  typedef struct packed {
    logic       parity;
    logic       parity_type;
    logic       stop_bits;
    logic [3:0] frame_length;
  } cfg_t;

  localparam cfg_t CFG_RST = '{parity: 1'b1, parity_type: 1'b0,
                               stop_bits: 1'b0, frame_length: 4'd8};

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_HOLD} state_t;

  function automatic logic addr_mapped(input logic [3:0] a);
    return (a >= ADDR_PAR) && (a <= ADDR_LOCK);
  endfunction

endpackage

// File: rtl/uart_cfg_channel.sv
// One channel's configuration state: shadow registers written by the host,
// active registers seen by TX/RX, commit-pending and sticky lock flags.
// Ports:
//   clk_16bd, rst  clock / async active-high reset
//   we             validated write strobe for this channel (top has already
//                  rejected locked / out-of-range / unmapped writes)
//   address, wd    register address and write data (low nibble)
//   ch_idle        no frame in flight; gates shadow->active transfer
//   active         configuration currently driven to TX/RX
//   locked         lock flag (write rejection is done in the top)
//   rd_val         read value for 'address', zero-extended to 4 bits
module uart_cfg_channel
  import uart_cfg_pkg::*;
(
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] address,
  input  logic [3:0] wd,
  input  logic       ch_idle,
  output cfg_t       active,
  output logic       locked,
  output logic [3:0] rd_val
);

  cfg_t shadow;
  logic pending;

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      shadow  <= CFG_RST;
      active  <= CFG_RST;
      pending <= 1'b0;
      locked  <= 1'b0;
    end else begin
      // Transfer samples the pre-edge shadow, so a shadow write on the same
      // edge is not captured; it waits for the next commit.
      if (pending && ch_idle) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (we) begin
        case (address)
          ADDR_PAR:    shadow.parity       <= wd[0];
          ADDR_PTYPE:  shadow.parity_type  <= wd[0];
          ADDR_STOP:   shadow.stop_bits    <= wd[0];
          ADDR_FLEN:   shadow.frame_length <= wd;
          // A new commit request overrides a same-edge transfer clear.
          ADDR_COMMIT: if (wd[0]) pending <= 1'b1;
          ADDR_LOCK:   if (wd[0]) locked  <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = 4'd0;
    case (address)
      ADDR_PAR:    rd_val = {3'd0, shadow.parity};
      ADDR_PTYPE:  rd_val = {3'd0, shadow.parity_type};
      ADDR_STOP:   rd_val = {3'd0, shadow.stop_bits};
      ADDR_FLEN:   rd_val = shadow.frame_length;
      ADDR_COMMIT: rd_val = {3'd0, pending};
      ADDR_LOCK:   rd_val = {3'd0, locked};
      default:     rd_val = 4'd0;
    endcase
  end

endmodule

// File: rtl/uart_cfg_regbank.sv
// Multi-channel UART configuration register bank with a valid/ack/nack
// handshake. A request is decoded and executed on the IDLE edge that sees
// valid; ack or nack pulses for the single RESP cycle; HOLD waits for valid
// to drop so a held strobe never repeats the access.
// Ports:
//   clk_16bd, rst         clock / async active-high reset
//   valid, wr, ch_sel,    request strobe, direction, channel, register
//   address, wdata        address and write data
//   rdata, ack, nack      response (rdata valid while ack high)
//   ch_idle               per-channel idle from TX/RX
//   parity, parity_type,  active per-channel settings; frame_length has
//   stop_bits,            channel n at bits [4n+3:4n]
//   frame_length
module uart_cfg_regbank
  import uart_cfg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 4,
  parameter int FL_MIN = 5,
  parameter int FL_MAX = 9,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_16bd,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [3:0]            address,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  nack,
  input  logic [NUM_CH-1:0]     ch_idle,
  output logic [NUM_CH-1:0]     parity,
  output logic [NUM_CH-1:0]     parity_type,
  output logic [NUM_CH-1:0]     stop_bits,
  output logic [4*NUM_CH-1:0]   frame_length
);

  state_t state, state_n;

  logic [NUM_CH-1:0]      sel, locked, we;
  logic [NUM_CH-1:0][3:0] rd_val;
  cfg_t [NUM_CH-1:0]      act;
  logic [3:0]             sel_rd;
  logic                   sel_lock, ch_ok, fl_bad, req_ok, access;

  // Channel select is one-hot over existing channels only, so an
  // out-of-range ch_sel selects nothing and is rejected via ch_ok.
  always_comb begin
    sel      = '0;
    sel_lock = 1'b0;
    sel_rd   = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]   = (int'(ch_sel) == i);
      sel_lock = sel_lock | (sel[i] & locked[i]);
      sel_rd   = sel_rd | (rd_val[i] & {4{sel[i]}});
    end
    ch_ok  = |sel;
    // Range check uses the full wdata so high bits cannot alias a legal value.
    fl_bad = wr && (address == ADDR_FLEN) &&
             ((int'(wdata) < FL_MIN) || (int'(wdata) > FL_MAX));
    req_ok = ch_ok && addr_mapped(address) && !(wr && (sel_lock || fl_bad));
    access = (state == ST_IDLE) && valid;
    we     = (access && wr && req_ok) ? sel : '0;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (valid)  state_n = ST_RESP;
      ST_RESP:             state_n = ST_HOLD;
      ST_HOLD: if (!valid) state_n = ST_IDLE;
      default:             state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      nack  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      ack   <= access && req_ok;
      nack  <= access && !req_ok;
      rdata <= (access && req_ok && !wr) ? DATA_W'(sel_rd) : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uart_cfg_channel u_ch (
      .clk_16bd (clk_16bd),
      .rst      (rst),
      .we       (we[g]),
      .address  (address),
      .wd       (wdata[3:0]),
      .ch_idle  (ch_idle[g]),
      .active   (act[g]),
      .locked   (locked[g]),
      .rd_val   (rd_val[g])
    );
    assign parity[g]             = act[g].parity;
    assign parity_type[g]        = act[g].parity_type;
    assign stop_bits[g]          = act[g].stop_bits;
    assign frame_length[4*g +: 4] = act[g].frame_length;
  end

endmodule
